mole_game_ctrl: RTL and testbench
=================================

// Module: mole_game_ctrl
// PURPOSE
//  Game sequencer in front of MOLE. Runs the IDLE/countdown/play/over flow and pulses MOLE.start.
//  Turns player hit pulses into MOLE.kill_list, scores hits and misses, and counts the game timer.
//  Raises difficulty by shrinking life_span and gen_interval on every level-up.
//  Sits between the button front-end and MOLE; score, level and time feed the display.
// PARAMETERS
//  LIFE_INIT 100 | initial life_span (ticks).   LIFE_MIN 20 | floor.   LIFE_DEC 10 | per-level decrement.
//  GEN_INIT 50 | initial gen_interval.          GEN_MIN 10 | floor.    GEN_DEC 5 | per-level decrement.
//  LEVEL_STEP 8 | hits per level; legal range 5..255.
//  MAX_MISS 5 | misses that end the game.
//  GAME_TICKS 3000 | play length in clk cycles.
//  CD_TICKS 150 | countdown length in clk cycles.
//  SCORE_W 10 | width of the score port.
// PORTS
//  clk          in   1        system clock, same clock as MOLE.clk
//  rst_n        in   1        asynchronous, active-low reset
//  btn_start    in   1        1-cycle pulse (debounced upstream)
//  hit          in   5        per-hole 1-cycle press pulses; multiple bits may be set at once
//  moles        in   20       from MOLE; slot i = moles[4i+3:4i], nonzero means a mole is up
//  mole_start   out  1        1-cycle pulse to MOLE.start
//  life_span    out  32       to MOLE.life_span
//  gen_interval out  32       to MOLE.gen_interval
//  kill_list    out  5        to MOLE.kill_list; registered 1-cycle pulses
//  score        out  SCORE_W  hit count, saturating at all-ones
//  misses       out  4        miss count
//  level        out  4        starts at 0, saturates at 15
//  time_left    out  32       play cycles remaining
//  game_over    out  1        high while in OVER
//  state        out  2        IDLE=0, CD=1, PLAY=2, OVER=3
// BEHAVIOUR
//  Reset values (async, any state):
//   state=IDLE, all counters=0, kill_list=0, mole_start=0,
//   life_span=LIFE_INIT, gen_interval=GEN_INIT, time_left=GAME_TICKS.
//  All outputs are registered.
//  FSM transitions:
//   IDLE --btn_start--> CD. Entering CD clears score, misses, level and step, restores INIT values,
//     and loads cd_cnt=CD_TICKS-1.
//   CD counts down; at cd_cnt==0 it goes to PLAY. mole_start=1 for exactly the first PLAY cycle.
//   PLAY decrements time_left each cycle. At time_left==1, or when misses reaches MAX_MISS, it goes to OVER.
//   Entering OVER drives kill_list=5'b11111 for 1 cycle to clear the board. game_over=1.
//   OVER --btn_start--> CD, which starts a new game.
//   btn_start in CD or PLAY is ignored.
//  Hit evaluation (PLAY only; hit is ignored in other states):
//   act[i] = (slot i != 0) & ~pend[i], where pend = kill_list issued the previous cycle.
//   good = hit & act; bad = hit & ~(slot nonzero).
//   A hit on a pending slot is neither good nor bad.
//   Next cycle: kill_list <= good; score += popcount(good), saturating; misses += popcount(bad), saturating at MAX_MISS.
//   A hit arriving in the same cycle as the OVER transition is discarded.
//  Level-up: step counter (8b) accumulates good hits.
//   If step + n >= LEVEL_STEP: step <= step + n - LEVEL_STEP, level++ (max 15),
//     life_span <= max(LIFE_MIN, life_span-LIFE_DEC), gen_interval <= max(GEN_MIN, gen_interval-GEN_DEC).
//   This gives at most one level per cycle.
//   Subtraction must not wrap: compare before subtracting.
//   New values are visible 1 cycle after the scoring cycle.
//  Win by miss and timeout in the same cycle: OVER, counts updated normally.
// STRUCTURE
//  Package mole_pkg holds: state enum, NUM_HOLES=5, SLOT_W=4, and function slot_up(moles,i).
//  Sub-module mole_hit_eval is combinational. It takes hit, moles and pend and returns good, bad,
//    n_good[2:0] and n_bad[2:0].
//  The FSM, counters and difficulty registers live in mole_game_ctrl.
// TESTING
//  Reset: rst_n=0 mid-PLAY -> state=0, kill_list=0, life_span=100 and gen_interval=50 in the same cycle.
//  Start: btn_start pulse -> state=1 for 150 cycles, then state=2 with one mole_start pulse; time_left=3000 then decrements.
//  Score/kill: moles slot1=4'h3, hit=5'b00010 -> next cycle kill_list=5'b00010 for 1 cycle, score=1.
//    Re-hit the slot the next cycle -> no score, no miss.
//  Multi-hit: slots 0,1,3 up, hit=5'b01111 -> kill_list=5'b01011, score+=3, misses+=1.
//  Level: 8 good hits -> level=1, life_span=90, gen_interval=45.
//    After 9 levels -> life_span=20 (floor), gen_interval=10 (floor), no wrap.
//  End: 5 misses -> state=3, game_over=1, one kill_list=5'b11111 pulse.
//    Timeout after 3000 cycles gives the same response. btn_start in OVER -> CD with score=0.

Source files
------------

// File: rtl/mole_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mole_pkg
//  Purpose  : Shared constants, FSM state encoding and helpers for the mole
//             game sequencer and its hit evaluator.
//  Contents : NUM_HOLES, SLOT_W, MOLES_W, state encoding ST_*, slot_up()
//  Revision : 1.0  initial release
// ============================================================================
package mole_pkg;

    localparam int NUM_HOLES = 5;
    localparam int SLOT_W    = 4;
    localparam int MOLES_W   = NUM_HOLES * SLOT_W;

    // Game flow state; the encoding is visible on the state port.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CD   = 2'd1;
    localparam state_t ST_PLAY = 2'd2;
    localparam state_t ST_OVER = 2'd3;

    // A slot holds a mole whenever its nibble is nonzero.
    function automatic logic slot_up(input logic [MOLES_W-1:0] moles, input int idx);
        return |moles[idx*SLOT_W +: SLOT_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mole_hit_eval.sv
`default_nettype none
// ============================================================================
//  Module   : mole_hit_eval
//  Purpose  : Combinational classification of player hits into good hits
//             (mole up and not already being killed) and bad hits (empty
//             hole), plus population counts of each.
//  Ports    : hit_i    [4:0]  per-hole press pulses (already gated to PLAY)
//             moles_i  [19:0] mole slots from MOLE
//             pend_i   [4:0]  kill_list issued the previous cycle
//             good_o   [4:0]  hits that score
//             bad_o    [4:0]  hits that count as misses
//             n_good_o [2:0]  popcount(good_o)
//             n_bad_o  [2:0]  popcount(bad_o)
//  Revision : 1.0  initial release
// ============================================================================
module mole_hit_eval
    import mole_pkg::*;
(
    input  logic [NUM_HOLES-1:0] hit_i,
    input  logic [MOLES_W-1:0]   moles_i,
    input  logic [NUM_HOLES-1:0] pend_i,
    output logic [NUM_HOLES-1:0] good_o,
    output logic [NUM_HOLES-1:0] bad_o,
    output logic [2:0]           n_good_o,
    output logic [2:0]           n_bad_o
);

    always_comb begin
        good_o   = '0;
        bad_o    = '0;
        n_good_o = '0;
        n_bad_o  = '0;
        for (int i = 0; i < NUM_HOLES; i++) begin
            // A slot that was killed last cycle may still read nonzero while
            // MOLE retires it; such a hit is neither good nor bad.
            good_o[i] = hit_i[i] & slot_up(moles_i, i) & ~pend_i[i];
            bad_o[i]  = hit_i[i] & ~slot_up(moles_i, i);
        end
        for (int i = 0; i < NUM_HOLES; i++) begin
            n_good_o = n_good_o + {2'b00, good_o[i]};
            n_bad_o  = n_bad_o  + {2'b00, bad_o[i]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mole_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mole_game_ctrl
//  Purpose  : Game sequencer in front of MOLE. Runs IDLE/countdown/play/over,
//             pulses mole_start, turns hits into kill_list pulses, scores
//             hits and misses, counts the play timer and raises difficulty
//             on every level-up.
//  Ports    : clk, rst_n (async active-low)
//             btn_start          start pulse
//             hit [4:0]          per-hole press pulses
//             moles [19:0]       mole slots from MOLE
//             mole_start         1-cycle pulse on the first PLAY cycle
//             life_span [31:0]   mole life to MOLE
//             gen_interval[31:0] mole spawn interval to MOLE
//             kill_list [4:0]    kill pulses to MOLE
//             score [SCORE_W-1:0], misses [3:0], level [3:0]
//             time_left [31:0]   play cycles remaining
//             game_over          high in OVER
//             state [1:0]        IDLE=0 CD=1 PLAY=2 OVER=3
//  Revision : 1.0  initial release
// ============================================================================
module mole_game_ctrl
    import mole_pkg::*;
#(
    parameter int unsigned LIFE_INIT  = 100,
    parameter int unsigned LIFE_MIN   = 20,
    parameter int unsigned LIFE_DEC   = 10,
    parameter int unsigned GEN_INIT   = 50,
    parameter int unsigned GEN_MIN    = 10,
    parameter int unsigned GEN_DEC    = 5,
    parameter int unsigned LEVEL_STEP = 8,
    parameter int unsigned MAX_MISS   = 5,
    parameter int unsigned GAME_TICKS = 3000,
    parameter int unsigned CD_TICKS   = 150,
    parameter int          SCORE_W    = 10
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_start,
    input  logic [NUM_HOLES-1:0] hit,
    input  logic [MOLES_W-1:0]   moles,
    output logic                 mole_start,
    output logic [31:0]          life_span,
    output logic [31:0]          gen_interval,
    output logic [NUM_HOLES-1:0] kill_list,
    output logic [SCORE_W-1:0]   score,
    output logic [3:0]           misses,
    output logic [3:0]           level,
    output logic [31:0]          time_left,
    output logic                 game_over,
    output logic [1:0]           state
);

    state_t               state_q,     state_d;
    logic [31:0]          cd_cnt_q,    cd_cnt_d;
    logic [31:0]          time_left_q, time_left_d;
    logic [31:0]          life_q,      life_d;
    logic [31:0]          gen_q,       gen_d;
    logic [SCORE_W-1:0]   score_q,     score_d;
    logic [3:0]           misses_q,    misses_d;
    logic [3:0]           level_q,     level_d;
    logic [7:0]           step_q,      step_d;
    logic [NUM_HOLES-1:0] kill_q,      kill_d;
    logic                 start_q,     start_d;
    logic                 over_q,      over_d;

    logic [NUM_HOLES-1:0] w_hit_play;
    logic [NUM_HOLES-1:0] w_good;
    logic [NUM_HOLES-1:0] w_bad;
    logic [2:0]           w_n_good;
    logic [2:0]           w_n_bad;
    logic [SCORE_W:0]     w_score_sum;
    logic [4:0]           w_miss_sum;
    logic [3:0]           w_miss_next;
    logic [8:0]           w_step_sum;
    logic [8:0]           w_step_wrap;
    logic                 w_level_up;
    logic                 w_new_game;

    // Hits outside PLAY never reach the evaluator.
    assign w_hit_play = (state_q == ST_PLAY) ? hit : '0;

    mole_hit_eval u_hit_eval (
        .hit_i    (w_hit_play),
        .moles_i  (moles),
        .pend_i   (kill_q),
        .good_o   (w_good),
        .bad_o    (w_bad),
        .n_good_o (w_n_good),
        .n_bad_o  (w_n_bad)
    );

    // Widened sums so that saturation and level wrap can be detected
    // before anything is truncated.
    assign w_score_sum = {1'b0, score_q} + {{(SCORE_W-2){1'b0}}, w_n_good};
    assign w_miss_sum  = {1'b0, misses_q} + {2'b00, w_n_bad};
    assign w_miss_next = (w_miss_sum >= 5'(MAX_MISS)) ? 4'(MAX_MISS) : w_miss_sum[3:0];
    assign w_step_sum  = {1'b0, step_q} + {6'b0, w_n_good};
    assign w_level_up  = (w_step_sum >= 9'(LEVEL_STEP));
    assign w_step_wrap = w_step_sum - 9'(LEVEL_STEP);
    assign w_new_game  = btn_start & ((state_q == ST_IDLE) | (state_q == ST_OVER));

    always_comb begin
        state_d     = state_q;
        cd_cnt_d    = cd_cnt_q;
        time_left_d = time_left_q;
        life_d      = life_q;
        gen_d       = gen_q;
        score_d     = score_q;
        misses_d    = misses_q;
        level_d     = level_q;
        step_d      = step_q;
        kill_d      = '0;
        start_d     = 1'b0;

        case (state_q)
            ST_CD: begin
                if (cd_cnt_q == 32'd0) begin
                    state_d = ST_PLAY;
                    start_d = 1'b1;
                end else begin
                    cd_cnt_d = cd_cnt_q - 32'd1;
                end
            end
            ST_PLAY: begin
                time_left_d = time_left_q - 32'd1;
                kill_d      = w_good;
                score_d     = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
                misses_d    = w_miss_next;
                if (w_level_up) begin
                    step_d  = w_step_wrap[7:0];
                    level_d = (level_q == 4'd15) ? level_q : level_q + 4'd1;
                    // Compare first so the floor is reached without wrapping.
                    life_d  = (life_q >= LIFE_MIN + LIFE_DEC) ? life_q - LIFE_DEC : LIFE_MIN;
                    gen_d   = (gen_q  >= GEN_MIN  + GEN_DEC)  ? gen_q  - GEN_DEC  : GEN_MIN;
                end else begin
                    step_d  = w_step_sum[7:0];
                end
                if ((time_left_q == 32'd1) || (w_miss_next == 4'(MAX_MISS))) begin
                    state_d = ST_OVER;
                    kill_d  = '1;      // sweep the board on the way out
                end
            end
            default: ;
        endcase

        if (w_new_game) begin
            state_d     = ST_CD;
            cd_cnt_d    = CD_TICKS - 1;
            time_left_d = GAME_TICKS;
            life_d      = LIFE_INIT;
            gen_d       = GEN_INIT;
            score_d     = '0;
            misses_d    = '0;
            level_d     = '0;
            step_d      = '0;
        end
    end

    assign over_d = (state_d == ST_OVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cd_cnt_q    <= '0;
            time_left_q <= GAME_TICKS;
            life_q      <= LIFE_INIT;
            gen_q       <= GEN_INIT;
            score_q     <= '0;
            misses_q    <= '0;
            level_q     <= '0;
            step_q      <= '0;
            kill_q      <= '0;
            start_q     <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cd_cnt_q    <= cd_cnt_d;
            time_left_q <= time_left_d;
            life_q      <= life_d;
            gen_q       <= gen_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            level_q     <= level_d;
            step_q      <= step_d;
            kill_q      <= kill_d;
            start_q     <= start_d;
            over_q      <= over_d;
        end
    end

    assign state        = state_q;
    assign time_left    = time_left_q;
    assign life_span    = life_q;
    assign gen_interval = gen_q;
    assign score        = score_q;
    assign misses       = misses_q;
    assign level        = level_q;
    assign kill_list    = kill_q;
    assign mole_start   = start_q;
    assign game_over    = over_q;

endmodule
`default_nettype wire

// File: tb/tb_mole_game_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mole_game_ctrl
//  Purpose  : Directed self-checking bench for mole_game_ctrl: reset values,
//             countdown/start, scoring and kill pulses, pending re-hits,
//             multi-hit, level-up and difficulty floors, miss and timeout
//             endings, restart and asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mole_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_start;
    logic [4:0]  hit;
    logic [19:0] moles;
    logic        mole_start;
    logic [31:0] life_span;
    logic [31:0] gen_interval;
    logic [4:0]  kill_list;
    logic [9:0]  score;
    logic [3:0]  misses;
    logic [3:0]  level;
    logic [31:0] time_left;
    logic        game_over;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;
    int exp_score;
    int cnt;
    int iter;

    mole_game_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_start    (btn_start),
        .hit          (hit),
        .moles        (moles),
        .mole_start   (mole_start),
        .life_span    (life_span),
        .gen_interval (gen_interval),
        .kill_list    (kill_list),
        .score        (score),
        .misses       (misses),
        .level        (level),
        .time_left    (time_left),
        .game_over    (game_over),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_start = 1'b0;
        hit       = '0;
        moles     = '0;
        tick(); tick();

        // ---------------- reset values ----------------
        check("rst_state", 32'(state), 0);
        check("rst_kill", 32'(kill_list), 0);
        check("rst_life", life_span, 100);
        check("rst_gen", gen_interval, 50);
        check("rst_time", time_left, 3000);
        check("rst_score", 32'(score), 0);
        check("rst_start", 32'(mole_start), 0);
        check("rst_over", 32'(game_over), 0);
        rst_n = 1'b1;
        tick();
        check("idle_hold", 32'(state), 0);

        // ---------------- countdown then play ----------------
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        check("cd_enter", 32'(state), 1);
        cnt = 1;
        while (state == 2'd1 && cnt < 300) begin
            tick();
            if (state == 2'd1) cnt++;
        end
        check("cd_len", cnt, 150);
        check("play_enter", 32'(state), 2);
        check("start_pulse", 32'(mole_start), 1);
        check("time_first", time_left, 3000);
        tick();
        check("start_drop", 32'(mole_start), 0);
        check("time_dec", time_left, 2999);

        // ---------------- single hit and pending re-hit ----------------
        moles = 20'h00030;
        hit = 5'b00010; tick(); hit = '0;
        check("kill_one", 32'(kill_list), 5'b00010);
        check("score_one", 32'(score), 1);
        hit = 5'b00010; tick(); hit = '0;
        check("rehit_kill", 32'(kill_list), 0);
        check("rehit_score", 32'(score), 1);
        check("rehit_miss", 32'(misses), 0);

        // ---------------- multi-hit: slots 0,1,3 up ----------------
        moles = 20'h03033;
        hit = 5'b01111; tick(); hit = '0;
        check("multi_kill", 32'(kill_list), 5'b01011);
        check("multi_score", 32'(score), 4);
        check("multi_miss", 32'(misses), 1);
        tick();

        // ---------------- level-up after 8 good hits ----------------
        moles = 20'h00003;
        repeat (3) begin
            hit = 5'b00001; tick(); hit = '0; tick();
        end
        check("lvl_before", 32'(level), 0);
        check("life_before", life_span, 100);
        hit = 5'b00001; tick(); hit = '0;
        check("lvl_one", 32'(level), 1);
        check("life_one", life_span, 90);
        check("gen_one", gen_interval, 45);
        check("score_eight", 32'(score), 8);
        exp_score = 8;
        tick();

        // ---------------- climb to level 9 and 10: floors, no wrap ----------------
        moles = 20'h33333;
        iter = 0;
        while (level != 4'd9 && iter < 40) begin
            hit = 5'b11111; tick(); hit = '0; exp_score += 5; tick(); iter++;
        end
        check("lvl_nine", 32'(level), 9);
        check("life_floor9", life_span, 20);
        check("gen_floor9", gen_interval, 10);
        iter = 0;
        while (level != 4'd10 && iter < 10) begin
            hit = 5'b11111; tick(); hit = '0; exp_score += 5; tick(); iter++;
        end
        check("lvl_ten", 32'(level), 10);
        check("life_floor10", life_span, 20);
        check("gen_floor10", gen_interval, 10);
        check("score_model", 32'(score), 32'(exp_score));

        // ---------------- end by misses ----------------
        moles = '0;
        repeat (3) begin
            hit = 5'b01000; tick(); hit = '0; tick();
        end
        check("miss_four", 32'(misses), 4);
        check("still_play", 32'(state), 2);
        hit = 5'b01000; tick(); hit = '0;
        check("miss_over", 32'(state), 3);
        check("miss_go", 32'(game_over), 1);
        check("miss_sweep", 32'(kill_list), 5'b11111);
        check("miss_five", 32'(misses), 5);
        tick();
        check("sweep_drop", 32'(kill_list), 0);
        moles = 20'h33333;
        hit = 5'b11111; tick(); hit = '0;
        check("over_nohit", 32'(score), 32'(exp_score));
        check("over_nokill", 32'(kill_list), 0);

        // ---------------- restart, CD ignores btn, timeout ----------------
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        check("re_cd", 32'(state), 1);
        check("re_score", 32'(score), 0);
        check("re_miss", 32'(misses), 0);
        check("re_level", 32'(level), 0);
        check("re_life", life_span, 100);
        check("re_gen", gen_interval, 50);
        check("re_go", 32'(game_over), 0);
        moles = '0;
        cnt = 1;
        while (state == 2'd1 && cnt < 300) begin
            btn_start = (cnt == 10);
            tick();
            btn_start = 1'b0;
            if (state == 2'd1) cnt++;
        end
        check("cd_len_btn", cnt, 150);
        check("re_time", time_left, 3000);
        cnt = 1;
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        check("play_btn_ign", 32'(state), 2);
        cnt++;
        while (state == 2'd2 && cnt < 3100) begin
            tick();
            if (state == 2'd2) cnt++;
        end
        check("play_len", cnt, 3000);
        check("to_over", 32'(state), 3);
        check("to_go", 32'(game_over), 1);
        check("to_sweep", 32'(kill_list), 5'b11111);
        check("to_time", time_left, 0);
        tick();
        check("to_sweep_drop", 32'(kill_list), 0);

        // ---------------- asynchronous reset mid-PLAY ----------------
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        iter = 0;
        while (state != 2'd2 && iter < 200) begin
            tick(); iter++;
        end
        check("g3_play", 32'(state), 2);
        moles = 20'h00300;
        hit = 5'b00100; tick(); hit = '0;
        check("g3_kill", 32'(kill_list), 5'b00100);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_kill", 32'(kill_list), 0);
        check("arst_life", life_span, 100);
        check("arst_gen", gen_interval, 50);
        check("arst_score", 32'(score), 0);
        check("arst_time", time_left, 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
